// File: rtl/johnson_pkg.sv
// Shared Johnson (twisted-ring) code helpers used by both the counter and decoder sides.
// Functions take the active width as an argument so one package serves every WIDTH up to MAX_WIDTH.
package johnson_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} jdec_state_t;

  typedef logic [MAX_WIDTH-1:0] jcode_t;

  function automatic jcode_t johnson_next(input jcode_t c, input int w);
    jcode_t n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH - 1; i++) begin
      if (i < w - 1) n[i] = c[i+1];
    end
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i == w - 1) n[i] = ~c[0];
    end
    return n;
  endfunction

  // A code is legal exactly when it appears in the 2*w-long ring walked from zero.
  function automatic logic johnson_legal(input jcode_t c, input int w);
    jcode_t cur;
    logic   ok;
    cur = '0;
    ok  = 1'b0;
    for (int k = 0; k < 2 * MAX_WIDTH; k++) begin
      if ((k < 2 * w) && (cur == c)) ok = 1'b1;
      cur = johnson_next(cur, w);
    end
    return ok;
  endfunction

  function automatic int johnson_phase(input jcode_t c, input int w);
    int   pop;
    logic msb;
    pop = 0;
    msb = 1'b0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) pop += int'(c[i]);
      if (i == w - 1) msb = c[i];
    end
    if (c == '0) return 0;
    else if (msb) return pop;
    else return 2 * w - pop;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational decode of one Johnson code word: legality, phase index, and whether
// it is the expected successor of the previously accepted code.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]             code,
  input  logic [WIDTH-1:0]             prev,
  output logic                         legal,
  output logic [$clog2(2*WIDTH)-1:0]   phase,
  output logic                         succ
);

  localparam int PW = $clog2(2 * WIDTH);

  jcode_t code_ext;
  jcode_t prev_ext;
  jcode_t next_ext;

  always_comb begin
    code_ext             = '0;
    prev_ext             = '0;
    code_ext[WIDTH-1:0]  = code;
    prev_ext[WIDTH-1:0]  = prev;
    next_ext             = johnson_next(prev_ext, WIDTH);
    legal                = johnson_legal(code_ext, WIDTH);
    succ                 = legal && (next_ext == code_ext);
    phase                = PW'(johnson_phase(code_ext, WIDTH));
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson phase receiver: decodes each sampled code and only trusts the phase once a
// hunt/verify/lock sequence has proven the stream coherent.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             code,
  output logic [$clog2(2*WIDTH)-1:0]   phase,
  output logic                         phase_valid,
  output logic                         code_err,
  output logic                         seq_err,
  output logic                         locked,
  output logic [7:0]                   err_count
);

  localparam int PW = $clog2(2 * WIDTH);

  jdec_state_t      state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [3:0]       run, run_n;
  logic [3:0]       loss, loss_n;
  logic [PW-1:0]    phase_n;
  logic             phase_valid_n, code_err_n, seq_err_n;
  logic [7:0]       err_count_n;

  logic             legal, succ;
  logic [PW-1:0]    phase_dec;

  johnson_code_check #(.WIDTH(WIDTH)) u_check (
    .code  (code),
    .prev  (prev),
    .legal (legal),
    .phase (phase_dec),
    .succ  (succ)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= HUNT;
      prev        <= '0;
      run         <= '0;
      loss        <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      prev        <= prev_n;
      run         <= run_n;
      loss        <= loss_n;
      phase       <= phase_n;
      phase_valid <= phase_valid_n;
      code_err    <= code_err_n;
      seq_err     <= seq_err_n;
      err_count   <= err_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    prev_n        = prev;
    run_n         = run;
    loss_n        = loss;
    phase_n       = phase;
    phase_valid_n = 1'b0;
    code_err_n    = 1'b0;
    seq_err_n     = 1'b0;
    err_count_n   = err_count;

    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (legal) begin
            prev_n  = code;
            run_n   = '0;
            state_n = VERIFY;
          end else begin
            code_err_n = 1'b1;
          end
        end
        VERIFY: begin
          if (!legal) begin
            code_err_n = 1'b1;
            state_n    = HUNT;
          end else if (succ) begin
            prev_n = code;
            run_n  = run + 4'd1;
            if (run + 4'd1 == 4'(LOCK_CNT)) begin
              state_n = LOCKED;
              loss_n  = '0;
            end
          end else begin
            seq_err_n = 1'b1;
            prev_n    = code;
            run_n     = '0;
          end
        end
        LOCKED: begin
          if (succ) begin
            prev_n        = code;
            phase_n       = phase_dec;
            phase_valid_n = 1'b1;
            loss_n        = '0;
          end else begin
            // A legal-but-wrong code still resynchronises prev so recovery can start from it.
            if (legal) begin
              seq_err_n = 1'b1;
              prev_n    = code;
            end else begin
              code_err_n = 1'b1;
            end
            loss_n = loss + 4'd1;
            if (loss + 4'd1 == 4'(LOSS_CNT)) begin
              state_n = HUNT;
              run_n   = '0;
            end
          end
        end
        default: state_n = HUNT;
      endcase

      if ((code_err_n || seq_err_n) && (err_count != 8'hFF)) begin
        err_count_n = err_count + 8'd1;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: stimulus pushes hand-computed expectations,
// a separate monitor pops and compares one cycle after each sample.
module tb_johnson_decoder;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [3:0] code;
  logic [2:0] phase;
  logic       phase_valid;
  logic       code_err;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_count;

  typedef struct {
    int ph;
    int pv;
    int ce;
    int se;
    int lk;
    int ec;
  } exp_t;

  exp_t exp_q[$];
  logic expect_now;
  int   total;
  int   bad;

  johnson_decoder #(.WIDTH(4), .LOCK_CNT(3), .LOSS_CNT(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .code        (code),
    .phase       (phase),
    .phase_valid (phase_valid),
    .code_err    (code_err),
    .seq_err     (seq_err),
    .locked      (locked),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply_stimulus(input logic rn, input logic iv, input logic [3:0] c,
                                input int ph, input int pv, input int ce, input int se,
                                input int lk, input int ec);
    exp_t e;
    @(negedge clk);
    reset_n  = rn;
    in_valid = iv;
    code     = c;
    e.ph = ph; e.pv = pv; e.ce = ce; e.se = se; e.lk = lk; e.ec = ec;
    exp_q.push_back(e);
    expect_now = 1'b1;
  endtask

  // Monitor: outputs for a sample taken at a rising edge are checked 1 time unit later.
  initial begin
    logic take;
    exp_t e;
    forever begin
      @(posedge clk);
      take       = expect_now;
      expect_now = 1'b0;
      #1;
      if (take) begin
        if (exp_q.size() == 0) begin
          check_output("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("phase",       int'(phase),       e.ph);
          check_output("phase_valid", int'(phase_valid), e.pv);
          check_output("code_err",    int'(code_err),    e.ce);
          check_output("seq_err",     int'(seq_err),     e.se);
          check_output("locked",      int'(locked),      e.lk);
          check_output("err_count",   int'(err_count),   e.ec);
        end
      end
    end
  end

  initial begin
    total      = 0;
    bad        = 0;
    expect_now = 1'b0;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    code       = 4'b0000;

    //             rn  iv  code     ph pv ce se lk ec
    apply_stimulus(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

    apply_stimulus(1, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 4'b1000, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 4'b1100, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 4'b1110, 0, 0, 0, 0, 1, 0);

    apply_stimulus(1, 1, 4'b1111, 4, 1, 0, 0, 1, 0);
    apply_stimulus(1, 1, 4'b0111, 5, 1, 0, 0, 1, 0);
    apply_stimulus(1, 1, 4'b0011, 6, 1, 0, 0, 1, 0);
    apply_stimulus(1, 1, 4'b0001, 7, 1, 0, 0, 1, 0);
    apply_stimulus(1, 1, 4'b0000, 0, 1, 0, 0, 1, 0);
    apply_stimulus(1, 1, 4'b1000, 1, 1, 0, 0, 1, 0);

    apply_stimulus(1, 1, 4'b1010, 1, 0, 1, 0, 1, 1);
    apply_stimulus(1, 1, 4'b1100, 2, 1, 0, 0, 1, 1);

    apply_stimulus(1, 1, 4'b1100, 2, 0, 0, 1, 1, 2);
    apply_stimulus(1, 1, 4'b1111, 2, 0, 0, 1, 0, 3);
    apply_stimulus(1, 1, 4'b0011, 2, 0, 0, 0, 0, 3);

    apply_stimulus(1, 1, 4'b0110, 2, 0, 1, 0, 0, 4);
    apply_stimulus(1, 1, 4'b0100, 2, 0, 1, 0, 0, 5);
    apply_stimulus(1, 0, 4'b0000, 2, 0, 0, 0, 0, 5);

    apply_stimulus(1, 1, 4'b0001, 2, 0, 0, 0, 0, 5);
    apply_stimulus(1, 1, 4'b0000, 2, 0, 0, 0, 0, 5);
    apply_stimulus(1, 1, 4'b1000, 2, 0, 0, 0, 0, 5);
    apply_stimulus(1, 1, 4'b1100, 2, 0, 0, 0, 1, 5);
    apply_stimulus(1, 1, 4'b1110, 3, 1, 0, 0, 1, 5);

    apply_stimulus(0, 1, 4'b1111, 0, 0, 0, 0, 0, 0);

    apply_stimulus(1, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 4'b1000, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 4'b1100, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 4'b1110, 0, 0, 0, 0, 1, 0);

    // First illegal word hits LOCKED (loss 1), the second drops to HUNT, the rest accumulate.
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1, 1, 4'b0101, 0, 0, 1, 0, (i == 0) ? 1 : 0,
                     (i + 1 > 255) ? 255 : i + 1);
    end

    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_output("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
